// File: rtl/fdiv_ctrl.sv
// Programmable clock divider: 50% duty clk_div, per-period tick, one-shot mode.
// A divisor write while running is held in a shadow register until the next wrap.
module fdiv_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 50000,
  parameter int TICK_W       = 16
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  output logic              busy,
  output logic              clk_div,
  output logic              tick,
  output logic              done,
  output logic [TICK_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ONCE
  } state_t;

  localparam logic [CNT_W-1:0]  HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TICK_W-1:0] TCK_ONE  = TICK_W'(1);

  state_t state, state_nx;

  logic [CNT_W-1:0]  half_reg, half_nx;
  logic [CNT_W-1:0]  shadow, shadow_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [TICK_W-1:0] tick_cnt_nx;
  logic pending, pending_nx;
  logic clk_div_nx, tick_nx, done_nx;
  logic cfg_err_nx, busy_nx;
  logic wr_ok, wrap;

  assign wr_ok = cfg_we && (cfg_half != '0);
  assign wrap  = (cnt == half_reg - CNT_ONE);

  always_comb begin
    state_nx    = state;
    half_nx     = half_reg;
    shadow_nx   = shadow;
    pending_nx  = pending;
    cnt_nx      = cnt;
    clk_div_nx  = clk_div;
    tick_nx     = 1'b0;
    done_nx     = 1'b0;
    cfg_err_nx  = cfg_we && (cfg_half == '0);
    busy_nx     = busy;
    tick_cnt_nx = tick_cnt;
    unique case (state)
      IDLE: begin
        if (wr_ok) half_nx = cfg_half;
        if (start && !stop) begin
          state_nx    = oneshot ? ONCE : RUN;
          cnt_nx      = '0;
          clk_div_nx  = 1'b0;
          tick_cnt_nx = '0;
          busy_nx     = 1'b1;
        end
      end
      RUN, ONCE: begin
        if (stop) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          clk_div_nx = 1'b0;
          busy_nx    = 1'b0;
        end else if (wrap) begin
          cnt_nx     = '0;
          clk_div_nx = !clk_div;
          if (pending) begin
            half_nx    = shadow;
            pending_nx = 1'b0;
          end
          if (!clk_div) begin
            tick_nx     = 1'b1;
            tick_cnt_nx = tick_cnt + TCK_ONE;
          end else if (state == ONCE) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
        // a write on a wrap cycle lands after the wrap's own update
        if (wr_ok) begin
          shadow_nx  = cfg_half;
          pending_nx = 1'b1;
        end
        if (state_nx == IDLE && pending_nx) begin
          half_nx    = shadow_nx;
          pending_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_reg <= HALF_RST;
      shadow   <= HALF_RST;
      pending  <= 1'b0;
      cnt      <= '0;
      clk_div  <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      busy     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nx;
      half_reg <= half_nx;
      shadow   <= shadow_nx;
      pending  <= pending_nx;
      cnt      <= cnt_nx;
      clk_div  <= clk_div_nx;
      tick     <= tick_nx;
      done     <= done_nx;
      cfg_err  <= cfg_err_nx;
      busy     <= busy_nx;
      tick_cnt <= tick_cnt_nx;
    end
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: tick/done events are queued with the cycle
// they must appear on and checked every cycle; other outputs checked inline.
module tb_fdiv_ctrl;

  localparam int CW = 16;
  localparam int TW = 4;

  logic          clk_100M = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [CW-1:0] cfg_half;
  logic          cfg_err;
  logic          start;
  logic          stop;
  logic          oneshot;
  logic          busy;
  logic          clk_div;
  logic          tick;
  logic          done;
  logic [TW-1:0] tick_cnt;

  typedef struct {
    int            cyc;
    logic [TW-1:0] cnt;
  } tk_t;

  tk_t tq[$];
  int  dq[$];
  int  cyc  = 0;
  int  ncmp = 0;
  int  nerr = 0;
  int  e0;
  int  e1;

  always #5 clk_100M = ~clk_100M;

  fdiv_ctrl #(
    .CNT_W(CW),
    .DEFAULT_HALF(4),
    .TICK_W(TW)
  ) dut (
    .clk_100M(clk_100M),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_half(cfg_half),
    .cfg_err(cfg_err),
    .start(start),
    .stop(stop),
    .oneshot(oneshot),
    .busy(busy),
    .clk_div(clk_div),
    .tick(tick),
    .done(done),
    .tick_cnt(tick_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic et;
    logic ed;
    tk_t  t;
    @(posedge clk_100M);
    #1;
    cyc++;
    et = (tq.size() > 0) && (tq[0].cyc == cyc);
    ed = (dq.size() > 0) && (dq[0] == cyc);
    ncmp++;
    assert (tick === et) else begin
      nerr++;
      $error("FAIL tick cyc=%0d: observed %b expected %b", cyc, tick, et);
    end
    ncmp++;
    assert (done === ed) else begin
      nerr++;
      $error("FAIL done cyc=%0d: observed %b expected %b", cyc, done, ed);
    end
    if (et) begin
      t = tq.pop_front();
      ncmp++;
      assert (tick_cnt === t.cnt) else begin
        nerr++;
        $error("FAIL tick_cnt cyc=%0d: observed %0d expected %0d",
               cyc, tick_cnt, t.cnt);
      end
    end
    if (ed) void'(dq.pop_front());
  endtask

  task automatic exp_tick(input int c, input int n);
    tk_t t;
    t.cyc = c;
    t.cnt = TW'(n);
    tq.push_back(t);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wr(input int v);
    cfg_we   = 1'b1;
    cfg_half = CW'(v);
    step();
    cfg_we   = 1'b0;
    cfg_half = '0;
  endtask

  task automatic go(input logic os);
    start   = 1'b1;
    oneshot = os;
    step();
    start   = 1'b0;
    oneshot = 1'b0;
    e0      = cyc;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_clkdiv"}, 32'(clk_div), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cfgerr"}, 32'(cfg_err), 0);
    chk({tag, "_tcnt"}, 32'(tick_cnt), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_half = '0;
    start    = 1'b0;
    stop     = 1'b0;
    oneshot  = 1'b0;
    #23;
    chk_rst("rst");
    rst_n = 1'b1;
    step();
    step();

    // periodic run at the default half-period of 4
    go(1'b0);
    chk("run_busy", 32'(busy), 1);
    exp_tick(e0 + 4, 1);
    exp_tick(e0 + 12, 2);
    exp_tick(e0 + 20, 3);
    run_to(e0 + 3);
    chk("run_lo3", 32'(clk_div), 0);
    run_to(e0 + 4);
    chk("run_hi4", 32'(clk_div), 1);
    run_to(e0 + 7);
    chk("run_hi7", 32'(clk_div), 1);
    run_to(e0 + 8);
    chk("run_lo8", 32'(clk_div), 0);
    run_to(e0 + 9);
    start   = 1'b1;
    oneshot = 1'b1;
    step();
    start   = 1'b0;
    oneshot = 1'b0;
    run_to(e0 + 21);
    chk("run_tcnt", 32'(tick_cnt), 3);
    halt();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_clk", 32'(clk_div), 0);

    // illegal write while idle
    wr(0);
    chk("err_idle", 32'(cfg_err), 1);
    step();
    chk("err_idle_off", 32'(cfg_err), 0);

    // one-shot with half 3
    wr(3);
    chk("wr3_noerr", 32'(cfg_err), 0);
    go(1'b1);
    chk("os_tcnt0", 32'(tick_cnt), 0);
    chk("os_busy", 32'(busy), 1);
    exp_tick(e0 + 3, 1);
    dq.push_back(e0 + 6);
    run_to(e0 + 2);
    chk("os_lo2", 32'(clk_div), 0);
    run_to(e0 + 3);
    chk("os_hi3", 32'(clk_div), 1);
    run_to(e0 + 5);
    chk("os_hi5", 32'(clk_div), 1);
    run_to(e0 + 6);
    chk("os_lo6", 32'(clk_div), 0);
    chk("os_busy6", 32'(busy), 0);
    run_to(e0 + 14);
    chk("os_tcnt", 32'(tick_cnt), 1);

    // divisor change mid half-period
    wr(4);
    go(1'b0);
    exp_tick(e0 + 4, 1);
    exp_tick(e0 + 10, 2);
    exp_tick(e0 + 14, 3);
    exp_tick(e0 + 18, 4);
    run_to(e0 + 5);
    wr(2);
    run_to(e0 + 7);
    chk("chg_hi7", 32'(clk_div), 1);
    run_to(e0 + 8);
    chk("chg_lo8", 32'(clk_div), 0);
    run_to(e0 + 9);
    chk("chg_lo9", 32'(clk_div), 0);
    run_to(e0 + 10);
    chk("chg_hi10", 32'(clk_div), 1);
    run_to(e0 + 18);
    halt();

    // divisor write exactly on a wrap: one extra 4-cycle half-period
    wr(4);
    go(1'b0);
    exp_tick(e0 + 4, 1);
    exp_tick(e0 + 10, 2);
    exp_tick(e0 + 14, 3);
    run_to(e0 + 3);
    wr(2);
    run_to(e0 + 7);
    chk("wwr_hi7", 32'(clk_div), 1);
    run_to(e0 + 9);
    chk("wwr_lo9", 32'(clk_div), 0);
    run_to(e0 + 17);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_clk", 32'(clk_div), 0);
    chk("ss_tcnt", 32'(tick_cnt), 3);
    step();
    chk("ss_idle", 32'(busy), 0);
    go(1'b0);
    e1 = e0;
    chk("rs_tcnt0", 32'(tick_cnt), 0);
    chk("rs_busy", 32'(busy), 1);
    exp_tick(e1 + 2, 1);
    run_to(e1 + 3);
    halt();

    // illegal write while busy leaves timing alone
    go(1'b0);
    exp_tick(e0 + 2, 1);
    exp_tick(e0 + 6, 2);
    exp_tick(e0 + 10, 3);
    run_to(e0 + 2);
    wr(0);
    chk("err_busy", 32'(cfg_err), 1);
    step();
    chk("err_busy_off", 32'(cfg_err), 0);
    run_to(e0 + 11);
    halt();

    // half 1 and tick counter wrap
    wr(1);
    go(1'b0);
    for (int k = 0; k < 17; k++) exp_tick(e0 + 1 + 2 * k, (k + 1) % 16);
    run_to(e0 + 1);
    chk("h1_hi", 32'(clk_div), 1);
    run_to(e0 + 2);
    chk("h1_lo", 32'(clk_div), 0);
    run_to(e0 + 34);
    halt();

    // asynchronous reset during a one-shot
    wr(5);
    go(1'b1);
    exp_tick(e0 + 5, 1);
    run_to(e0 + 7);
    chk("ar_pre", 32'(clk_div), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("arst");
    step();
    step();
    chk_rst("arst_hold");
    rst_n = 1'b1;
    go(1'b0);
    exp_tick(e0 + 4, 1);
    exp_tick(e0 + 12, 2);
    run_to(e0 + 7);
    chk("dflt_hi7", 32'(clk_div), 1);
    run_to(e0 + 8);
    chk("dflt_lo8", 32'(clk_div), 0);
    run_to(e0 + 13);
    halt();
    step();

    chk("tq_empty", 32'(tq.size()), 0);
    chk("dq_empty", 32'(dq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
